dm_cache_ctrl: RTL and testbench

Parametrised direct-mapped read cache controller with valid/ready request and response handshakes toward the core, and a line-refill handshake toward backing memory. It succeeds the fixed 4K-word cache: geometry is generic, lookup and refill run under an explicit FSM, and hit/miss statistics count exactly once per transaction. It sits between the core's load port and the memory model.

---
 rtl/dm_cache_pkg.sv | 39 +++
 rtl/dm_cache_line_store.sv | 56 +++++
 rtl/dm_cache_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// ============================================================================
//  Module      : dm_cache_pkg
//  Description : Shared state encoding and address-field width helpers for the
//                direct-mapped cache controller. The FLUSH state exists only
//                when CACHE_FLUSH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_cache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEMREQ  = 3'd2,
        MEMWAIT = 3'd3,
        RESP    = 3'd4
`ifdef CACHE_FLUSH_EN
        ,
        FLUSH   = 3'd5
`endif
    } state_t;

    function automatic int offsetW(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int indexW(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever address bits remain above {index, offset}.
    function automatic int tagW(input int addrW, input int wordsPerLine, input int lines);
        return addrW - $clog2(wordsPerLine) - $clog2(lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_cache_line_store.sv
// ============================================================================
//  Module      : dm_cache_line_store
//  Description : Valid vector (async clear), tag array and data array with one
//                write port and one combinational read port indexed by line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_cache_line_store #(
    parameter int TAG_W          = 3,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 1024,
    parameter int INDEX_W        = $clog2(LINES),
    parameter int LINE_W         = WORDS_PER_LINE * WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrEn,
    input  logic               wrValid,
    input  logic [INDEX_W-1:0] wrIdx,
    input  logic [TAG_W-1:0]   wrTag,
    input  logic [LINE_W-1:0]  wrLine,
    input  logic [INDEX_W-1:0] rdIdx,
    output logic               rdValid,
    output logic [TAG_W-1:0]   rdTag,
    output logic [LINE_W-1:0]  rdLine
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tagMem  [LINES];
    logic [LINE_W-1:0] r_dataMem [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (wrEn) begin
            r_valid[wrIdx] <= wrValid;
        end
    end

    // Invalidation writes (wrValid=0) leave stale tag/data untouched.
    always_ff @(posedge clk) begin
        if (wrEn && wrValid) begin
            r_tagMem[wrIdx]  <= wrTag;
            r_dataMem[wrIdx] <= wrLine;
        end
    end

    assign rdValid = r_valid[rdIdx];
    assign rdTag   = r_tagMem[rdIdx];
    assign rdLine  = r_dataMem[rdIdx];

endmodule

`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
// ============================================================================
//  Module      : dm_cache_ctrl
//  Description : Direct-mapped read cache controller with core request/response
//                handshakes, single-beat line refill and saturating hit/miss
//                counters. Define CACHE_FLUSH_EN to add flush_req/flush_done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
`ifdef CACHE_FLUSH_EN
    input  logic                             flush_req,
    output logic                             flush_done,
`endif
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_W-1:0]                req_addr,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [WORD_W-1:0]                rsp_data,
    output logic                             rsp_hit,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_W-1:0]                mem_req_addr,
    input  logic                             mem_rsp_valid,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] mem_rsp_data,
    output logic [CNT_W-1:0]                 hit_count,
    output logic [CNT_W-1:0]                 miss_count
);

    localparam int c_OFFSET_W = offsetW(WORDS_PER_LINE);
    localparam int c_INDEX_W  = indexW(LINES);
    localparam int c_TAG_W    = tagW(ADDR_W, WORDS_PER_LINE, LINES);
    localparam int c_LINE_W   = WORDS_PER_LINE * WORD_W;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_live;
    logic [ADDR_W-1:0]     r_reqAddr;
    logic [WORD_W-1:0]     r_rspData;
    logic                  r_rspHit;
    logic [ADDR_W-1:0]     r_memReqAddr;
    logic [CNT_W-1:0]      r_hitCount;
    logic [CNT_W-1:0]      r_missCount;

    logic [c_OFFSET_W-1:0] w_reqOffset;
    logic [c_INDEX_W-1:0]  w_reqIdx;
    logic [c_TAG_W-1:0]    w_reqTag;
    logic                  w_rdValid;
    logic [c_TAG_W-1:0]    w_rdTag;
    logic [c_LINE_W-1:0]   w_rdLine;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_wrEn;
    logic                  w_wrValid;
    logic [c_INDEX_W-1:0]  w_wrIdx;
    logic [WORD_W-1:0]     w_hitWords    [WORDS_PER_LINE];
    logic [WORD_W-1:0]     w_refillWords [WORDS_PER_LINE];

    assign w_reqOffset = r_reqAddr[c_OFFSET_W-1:0];
    assign w_reqIdx    = r_reqAddr[c_OFFSET_W +: c_INDEX_W];
    assign w_reqTag    = r_reqAddr[ADDR_W-1 -: c_TAG_W];

    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_wordSplit
            assign w_hitWords[gi]    = w_rdLine[gi*WORD_W +: WORD_W];
            assign w_refillWords[gi] = mem_rsp_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign w_hit = w_rdValid && (w_rdTag == w_reqTag);

`ifdef CACHE_FLUSH_EN
    logic                 r_flushPending;
    logic [c_INDEX_W-1:0] r_flushIdx;
    logic                 w_flushWant;

    // A flush request (new or latched while busy) takes priority over loads.
    assign w_flushWant = flush_req || r_flushPending;
    assign req_ready   = r_live && (r_state == IDLE) && !w_flushWant;
    assign flush_done  = (r_state == FLUSH) && (r_flushIdx == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flushPending <= 1'b0;
            r_flushIdx     <= '0;
        end else begin
            if (r_state == IDLE && r_live) begin
                r_flushPending <= 1'b0;
            end else if (flush_req) begin
                r_flushPending <= 1'b1;
            end
            if (r_state == FLUSH) begin
                r_flushIdx <= r_flushIdx + c_INDEX_W'(1);
            end
        end
    end
`else
    assign req_ready = r_live && (r_state == IDLE);
`endif

    assign w_accept      = req_valid && req_ready;
    assign rsp_valid     = (r_state == RESP);
    assign rsp_data      = r_rspData;
    assign rsp_hit       = r_rspHit;
    assign mem_req_valid = (r_state == MEMREQ);
    assign mem_req_addr  = r_memReqAddr;
    assign hit_count     = r_hitCount;
    assign miss_count    = r_missCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_live) begin
`ifdef CACHE_FLUSH_EN
                    if (w_flushWant) begin
                        w_stateNext = FLUSH;
                    end else if (req_valid) begin
                        w_stateNext = LOOKUP;
                    end
`else
                    if (req_valid) begin
                        w_stateNext = LOOKUP;
                    end
`endif
                end
            end
            LOOKUP:  w_stateNext = w_hit ? RESP : MEMREQ;
            MEMREQ:  if (mem_req_ready) w_stateNext = MEMWAIT;
            MEMWAIT: if (mem_rsp_valid) w_stateNext = RESP;
            RESP:    if (rsp_ready) w_stateNext = IDLE;
`ifdef CACHE_FLUSH_EN
            FLUSH:   if (r_flushIdx == '1) w_stateNext = IDLE;
`endif
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_wrEn    = 1'b0;
        w_wrValid = 1'b0;
        w_wrIdx   = w_reqIdx;
        if (r_state == MEMWAIT && mem_rsp_valid) begin
            w_wrEn    = 1'b1;
            w_wrValid = 1'b1;
        end
`ifdef CACHE_FLUSH_EN
        if (r_state == FLUSH) begin
            w_wrEn  = 1'b1;
            w_wrIdx = r_flushIdx;
        end
`endif
    end

    // r_live keeps req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live       <= 1'b0;
            r_reqAddr    <= '0;
            r_rspData    <= '0;
            r_rspHit     <= 1'b0;
            r_memReqAddr <= '0;
            r_hitCount   <= '0;
            r_missCount  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_reqAddr <= req_addr;
            end
            if (r_state == LOOKUP) begin
                if (w_hit) begin
                    r_rspData <= w_hitWords[w_reqOffset];
                    r_rspHit  <= 1'b1;
                    if (r_hitCount != '1) begin
                        r_hitCount <= r_hitCount + CNT_W'(1);
                    end
                end else begin
                    r_memReqAddr <= {w_reqTag, w_reqIdx, c_OFFSET_W'(0)};
                    if (r_missCount != '1) begin
                        r_missCount <= r_missCount + CNT_W'(1);
                    end
                end
            end
            if (r_state == MEMWAIT && mem_rsp_valid) begin
                r_rspData <= w_refillWords[w_reqOffset];
                r_rspHit  <= 1'b0;
            end
        end
    end

    dm_cache_line_store #(
        .TAG_W          (c_TAG_W),
        .WORD_W         (WORD_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES          (LINES),
        .INDEX_W        (c_INDEX_W),
        .LINE_W         (c_LINE_W)
    ) u_lineStore (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrEn    (w_wrEn),
        .wrValid (w_wrValid),
        .wrIdx   (w_wrIdx),
        .wrTag   (w_reqTag),
        .wrLine  (mem_rsp_data),
        .rdIdx   (w_reqIdx),
        .rdValid (w_rdValid),
        .rdTag   (w_rdTag),
        .rdLine  (w_rdLine)
    );

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
// ============================================================================
//  Module      : tb_dm_cache_ctrl
//  Description : Randomized self-checking bench for dm_cache_ctrl against a
//                line-level cache/backing-memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dm_cache_ctrl;

    localparam int c_ADDR_W = 15;
    localparam int c_WORD_W = 32;
    localparam int c_WPL    = 4;
    localparam int c_LINES  = 16;
    localparam int c_CNT_W  = 4;
    localparam int c_LINE_W = c_WPL * c_WORD_W;
    localparam int c_OFF_W  = 2;
    localparam int c_IDX_W  = 4;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                rsp_ready = 1'b0;
    logic                mem_req_ready = 1'b0;
    logic                mem_rsp_valid = 1'b0;
    logic [c_ADDR_W-1:0] req_addr = '0;
    logic [c_LINE_W-1:0] mem_rsp_data = '0;
    logic                req_ready, rsp_valid, rsp_hit, mem_req_valid;
    logic [c_WORD_W-1:0] rsp_data;
    logic [c_ADDR_W-1:0] mem_req_addr;
    logic [c_CNT_W-1:0]  hit_count, miss_count;
`ifdef CACHE_FLUSH_EN
    logic                flush_req = 1'b0;
    logic                flush_done;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl #(
        .ADDR_W         (c_ADDR_W),
        .WORD_W         (c_WORD_W),
        .WORDS_PER_LINE (c_WPL),
        .LINES          (c_LINES),
        .CNT_W          (c_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef CACHE_FLUSH_EN
        .flush_req     (flush_req),
        .flush_done    (flush_done),
`endif
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_hit       (rsp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Reference model: backing memory plus per-line valid/tag of the cache.
    logic [c_WORD_W-1:0] backMem [1 << c_ADDR_W];
    bit                  mValid  [c_LINES];
    int                  mTag    [c_LINES];
    int                  expHits = 0;
    int                  expMisses = 0;
    int                  nChecks = 0;
    int                  nErrors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > c_CNT_MAX) ? c_CNT_MAX : v;
    endfunction

    task automatic driveLine(input int base);
        for (int w = 0; w < c_WPL; w++) begin
            mem_rsp_data[w*c_WORD_W +: c_WORD_W] = backMem[base + w];
        end
    endtask

    task automatic waitReady();
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic doRead(input logic [c_ADDR_W-1:0] addr, input int rspHold, input int memHold);
        int idx, tag, base, cyc;
        bit expHit, done, sawMem;
        logic [c_WORD_W-1:0] d0;
        logic h0;
        idx    = (int'(addr) >> c_OFF_W) % c_LINES;
        tag    = int'(addr) >> (c_OFF_W + c_IDX_W);
        base   = int'(addr) & ~(c_WPL - 1);
        expHit = mValid[idx] && (mTag[idx] == tag);
        waitReady();
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = c_ADDR_W'($urandom);
        cyc = 1; done = 0; sawMem = 0;
        while (!done && cyc < 300) begin
            if (mem_req_valid) begin
                sawMem = 1;
                check("mem_req_addr", mem_req_addr, base);
                for (int i = 0; i < memHold; i++) begin
                    @(negedge clk);
                    cyc++;
                    check("mem_req_hold", {mem_req_valid, mem_req_addr}, {1'b1, 15'(base)});
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                cyc++;
                mem_req_ready = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    cyc++;
                end
                driveLine(base);
                mem_rsp_valid = 1'b1;
                @(negedge clk);
                cyc++;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end else if (rsp_valid) begin
                if (expHit) check("hit_latency", cyc, 2);
                check("rsp_data", rsp_data, backMem[addr]);
                check("rsp_hit", rsp_hit, expHit);
                d0 = rsp_data;
                h0 = rsp_hit;
                for (int i = 0; i < rspHold; i++) begin
                    @(negedge clk);
                    check("rsp_hold", {rsp_valid, req_ready, h0, rsp_data}, {1'b1, 1'b0, rsp_hit, d0});
                end
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("rsp_done", done, 1);
        check("mem_req_seen", sawMem, !expHit);
        if (expHit) begin
            expHits++;
        end else begin
            expMisses++;
            mValid[idx] = 1;
            mTag[idx]   = tag;
        end
        check("hit_count", hit_count, sat(expHits));
        check("miss_count", miss_count, sat(expMisses));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_hit, mem_req_valid}, 4'b0000);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_mem_addr"}, mem_req_addr, 0);
        check({tag, "_counts"}, {hit_count, miss_count}, 0);
    endtask

    task automatic resetInMemwait(input logic [c_ADDR_W-1:0] addr);
        int t;
        waitReady();
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!mem_req_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_mem_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("abort_in_memwait", {rsp_valid, mem_req_valid}, 2'b00);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        driveLine(int'(addr) & ~(c_WPL - 1));
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_dropped", {rsp_valid, mem_req_valid, rsp_data}, 0);
        for (int i = 0; i < c_LINES; i++) mValid[i] = 0;
        expHits = 0;
        expMisses = 0;
    endtask

    initial begin
        logic [c_ADDR_W-1:0] a;
        for (int i = 0; i < (1 << c_ADDR_W); i++) begin
            backMem[i] = (i * 32'h9E37_79B1) ^ 32'h0123_4567;
        end
        backMem[4] = 32'hAA;
        backMem[5] = 32'hBB;
        backMem[6] = 32'hCC;
        backMem[7] = 32'hDD;
        for (int i = 0; i < c_LINES; i++) mValid[i] = 0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1);

        doRead(15'h0005, 0, 0);
        doRead(15'h0006, 0, 0);
        doRead(15'h1005, 0, 0);
        doRead(15'h0005, 0, 0);
        doRead(15'h0006, 5, 0);
        doRead(15'h2009, 2, 3);

        resetInMemwait(15'h0040);
        doRead(15'h0005, 0, 0);

        repeat (20) doRead(15'h0006, $urandom_range(0, 1), 0);

        repeat (80) begin
            a = c_ADDR_W'(($urandom_range(0, 3) << (c_OFF_W + c_IDX_W))
                        | ($urandom_range(0, c_LINES - 1) << c_OFF_W)
                        | $urandom_range(0, c_WPL - 1));
            doRead(a, $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef CACHE_FLUSH_EN
        begin
            int cyc;
            doRead(15'h0005, 0, 0);
            waitReady();
            flush_req = 1'b1;
            @(negedge clk);
            flush_req = 1'b0;
            cyc = 1;
            while (!flush_done && cyc < 100) begin
                check("flush_req_ready", req_ready, 0);
                @(negedge clk);
                cyc++;
            end
            check("flush_done_latency", cyc, c_LINES);
            @(negedge clk);
            check("flush_done_pulse", flush_done, 0);
            for (int i = 0; i < c_LINES; i++) mValid[i] = 0;
            doRead(15'h0005, 0, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
